// File: rtl/biquad8_coeff_ctrl.sv
// rtl/biquad8_coeff_ctrl.sv - WISHBONE coefficient shadow bank streamed to biquad channels on commit
`timescale 1ns/1ps
module biquad8_coeff_ctrl #(
    parameter int NCHAN     = 4,
    parameter int NCOEFF    = 16,
    parameter int CBITS     = 18,
    parameter int ADDR_BITS = 12,
    localparam int IW       = $clog2(NCOEFF),
    localparam int CHW      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [ADDR_BITS-1:0] wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o,
    input  logic                 global_update_i,
    output logic [CBITS-1:0]     coeff_dat_o,
    output logic [IW-1:0]        coeff_adr_o,
    output logic [CHW-1:0]       coeff_chan_o,
    output logic                 coeff_wr_o,
    output logic                 coeff_update_o,
    output logic                 busy_o
);

    localparam int NWORD = NCHAN * NCOEFF;
    localparam logic [IW-1:0] IDX_LAST = IW'(NCOEFF - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_UPDATE} state_t;
    state_t state_q, state_d;

    logic [CBITS-1:0] shadow_q [NWORD];
    logic [NCHAN-1:0] chmask_q, snap_q;
    logic [7:0]       cnt_q;
    logic             commit_pend_q, upd_pend_q, upd_commit_q;
    logic [CHW-1:0]   cur_chan_q;
    logic [IW-1:0]    cur_idx_q;
    logic             ack_q, err_q;
    logic [31:0]      dat_q;

    logic [31:0]         word, dec_chan;
    logic [IW-1:0]       dec_idx;
    logic [CHW+IW-1:0]   dec_flat, str_flat;
    logic                is_coef, chan_ok, is_ctrl, is_mask, busy;
    logic                req, stall, acc, acc_bad, wr_en, commit_set;
    logic [31:0]         rd_data;
    logic [CHW-1:0]      first_chan, nxt_chan;
    logic                nxt_found, take_commit, take_upd;
    logic                unused;

    assign word     = 32'(wb_adr_i[ADDR_BITS-2:2]);
    assign dec_chan = word >> IW;
    assign dec_idx  = word[IW-1:0];
    assign dec_flat = {dec_chan[CHW-1:0], dec_idx};
    assign str_flat = {cur_chan_q, cur_idx_q};
    assign is_coef  = wb_adr_i[ADDR_BITS-1];
    assign chan_ok  = dec_chan < 32'(NCHAN);
    assign is_ctrl  = !is_coef && word == 32'd0;
    assign is_mask  = !is_coef && word == 32'd1;
    assign busy     = state_q != S_IDLE;

    // The strobe stays up during the ack cycle; the ack/err guard prevents a second termination.
    assign req        = wb_cyc_i && wb_stb_i && !ack_q && !err_q;
    assign stall      = is_coef && chan_ok && wb_we_i && busy;
    assign acc        = req && !stall;
    assign acc_bad    = acc && is_coef && !chan_ok;
    assign wr_en      = acc && wb_we_i && !acc_bad;
    assign commit_set = wr_en && is_ctrl && wb_sel_i[0] && wb_dat_i[0];

    assign unused = &{1'b0, wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i};

    always_comb begin
        rd_data = '0;
        if (is_ctrl)
            rd_data = {16'h0, cnt_q, 7'h0, busy};
        else if (is_mask)
            rd_data = 32'(chmask_q);
        else if (is_coef && chan_ok)
            rd_data = 32'(shadow_q[dec_flat]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
            chmask_q <= '1;
            for (int i = 0; i < NWORD; i++)
                shadow_q[i] <= '0;
        end else begin
            ack_q <= acc && !acc_bad;
            err_q <= acc_bad;
            dat_q <= (acc && !wb_we_i && !acc_bad) ? rd_data : '0;
            if (wr_en && is_mask)
                chmask_q <= wb_dat_i[NCHAN-1:0];
            if (wr_en && is_coef)
                shadow_q[dec_flat] <= wb_dat_i[CBITS-1:0];
        end
    end

    assign wb_ack_o = ack_q && wb_cyc_i;
    assign wb_err_o = err_q && wb_cyc_i;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = dat_q;

    // Lowest enabled channel of the live mask, and next enabled channel above the current one.
    always_comb begin
        first_chan = '0;
        nxt_chan   = '0;
        nxt_found  = 1'b0;
        for (int c = NCHAN - 1; c >= 0; c--) begin
            if (chmask_q[c])
                first_chan = CHW'(c);
            if (snap_q[c] && c > int'(cur_chan_q)) begin
                nxt_chan  = CHW'(c);
                nxt_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        take_commit = 1'b0;
        take_upd    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (commit_pend_q) begin
                    take_commit = 1'b1;
                    if (|chmask_q)
                        state_d = S_STREAM;
                    else
                        state_d = S_UPDATE;
                end else if (upd_pend_q || global_update_i) begin
                    take_upd = 1'b1;
                    state_d  = S_UPDATE;
                end
            end
            S_STREAM: begin
                if (cur_idx_q == IDX_LAST && !nxt_found)
                    state_d = S_UPDATE;
            end
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            snap_q        <= '0;
            cur_chan_q    <= '0;
            cur_idx_q     <= '0;
            cnt_q         <= '0;
            commit_pend_q <= 1'b0;
            upd_pend_q    <= 1'b0;
            upd_commit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // A pending global update is absorbed by the commit's own update pulse.
            if (take_commit) begin
                snap_q       <= chmask_q;
                cur_chan_q   <= first_chan;
                cur_idx_q    <= '0;
                upd_commit_q <= 1'b1;
                upd_pend_q   <= 1'b0;
            end
            if (take_upd) begin
                upd_commit_q <= 1'b0;
                upd_pend_q   <= 1'b0;
            end
            if (state_q == S_STREAM) begin
                cur_idx_q <= cur_idx_q + 1'b1;
                if (cur_idx_q == IDX_LAST && nxt_found)
                    cur_chan_q <= nxt_chan;
            end
            if (state_q == S_UPDATE) begin
                if (upd_commit_q)
                    cnt_q <= cnt_q + 8'd1;
                if (global_update_i)
                    upd_pend_q <= 1'b1;
            end
            if (commit_set)
                commit_pend_q <= 1'b1;
            else if (take_commit)
                commit_pend_q <= 1'b0;
        end
    end

    assign busy_o         = busy;
    assign coeff_wr_o     = state_q == S_STREAM;
    assign coeff_update_o = state_q == S_UPDATE;
    assign coeff_chan_o   = coeff_wr_o ? cur_chan_q : '0;
    assign coeff_adr_o    = coeff_wr_o ? cur_idx_q : '0;
    assign coeff_dat_o    = coeff_wr_o ? shadow_q[str_flat] : '0;

endmodule

// File: tb/tb_biquad8_coeff_ctrl.sv
// tb/tb_biquad8_coeff_ctrl.sv - directed self-checking bench for biquad8_coeff_ctrl
`timescale 1ns/1ps
module tb_biquad8_coeff_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [11:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic        global_update_i = 1'b0;
    logic [17:0] coeff_dat_o;
    logic [3:0]  coeff_adr_o;
    logic [1:0]  coeff_chan_o;
    logic        coeff_wr_o, coeff_update_o, busy_o;

    biquad8_coeff_ctrl #(.NCHAN(4), .NCOEFF(16), .CBITS(18), .ADDR_BITS(12)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .global_update_i(global_update_i),
        .coeff_dat_o(coeff_dat_o), .coeff_adr_o(coeff_adr_o), .coeff_chan_o(coeff_chan_o),
        .coeff_wr_o(coeff_wr_o), .coeff_update_o(coeff_update_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int wr_cyc_q[$], wr_chan_q[$], wr_adr_q[$], wr_dat_q[$], upd_q[$];
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (coeff_wr_o) begin
                wr_cyc_q.push_back(cyc);
                wr_chan_q.push_back(int'(coeff_chan_o));
                wr_adr_q.push_back(int'(coeff_adr_o));
                wr_dat_q.push_back(int'(coeff_dat_o));
            end
            if (coeff_update_o)
                upd_q.push_back(cyc);
        end
    end

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] r_dat;
    logic        r_ack, r_err;
    int          r_t0, r_lat, n, n0, g, quiet;
    logic [17:0] exp_coef [64];
    int          exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] caddr(input int ch, input int idx);
        return 12'(32'h800 + (ch * 16 + idx) * 4);
    endfunction

    function automatic int upd_at(input int i);
        return (i < upd_q.size()) ? upd_q[i] : -1;
    endfunction

    task automatic xfer(input logic we, input logic [11:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
        r_t0 = cyc; r_ack = 1'b0; r_err = 1'b0; r_dat = '0; r_lat = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            if (wb_ack_o || wb_err_o) begin
                r_ack = wb_ack_o; r_err = wb_err_o; r_dat = wb_dat_o; r_lat = cyc - r_t0;
                break;
            end
        end
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [11:0] adr, input logic [31:0] dat);
        xfer(1'b1, adr, dat, 4'hF);
        check("wr_ack", 32'(r_ack), 32'd1);
    endtask

    task automatic rd(input string tag, input logic [11:0] adr, input logic [31:0] exp);
        xfer(1'b0, adr, 32'h0, 4'hF);
        check(tag, r_dat, exp);
        check("rd_lat", r_lat, 32'd1);
    endtask

    task automatic commit();
        wr(12'h000, 32'h1);
        n = r_t0 + r_lat;
    endtask

    task automatic clr_mon();
        wr_cyc_q.delete(); wr_chan_q.delete(); wr_adr_q.delete(); wr_dat_q.delete(); upd_q.delete();
    endtask

    task automatic wait_quiet();
        quiet = 0;
        for (int k = 0; k < 500 && quiet < 3; k++) begin
            @(negedge clk_i);
            quiet = busy_o ? 0 : quiet + 1;
        end
        check("quiet", 32'(quiet >= 3), 32'd1);
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target - 1) @(negedge clk_i);
        @(posedge clk_i); #1;
    endtask

    task automatic check_stream(input int base, input int ch);
        check("st_len", 32'(wr_cyc_q.size() >= base + 16), 32'd1);
        if (wr_cyc_q.size() >= base + 16) begin
            for (int i = 0; i < 16; i++) begin
                check("st_chan", wr_chan_q[base + i], ch);
                check("st_adr", wr_adr_q[base + i], i);
                check("st_dat", wr_dat_q[base + i], 32'(exp_coef[ch * 16 + i]));
                check("st_gap", wr_cyc_q[base + i] - wr_cyc_q[base], i);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_flags", 32'({wb_ack_o, wb_err_o, wb_rty_o, coeff_wr_o, coeff_update_o, busy_o}), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_coeff", 32'({coeff_dat_o, coeff_adr_o, coeff_chan_o}), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        rd("rst_mask", 12'h004, 32'h0000_000F);
        rd("rst_ctrl", 12'h000, 32'h0);
        rd("unmapped", 12'h008, 32'h0);

        wr(caddr(2, 5), 32'h0003_FFFF);
        check("wr_lat", r_lat, 32'd1);
        rd("c25_rb", caddr(2, 5), 32'h0003_FFFF);
        wr(caddr(1, 7), 32'hFFFF_FFFF);
        rd("c17_trunc", caddr(1, 7), 32'h0003_FFFF);

        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 16; i++) begin
                exp_coef[c * 16 + i] = 18'((c << 16) | (i << 12) | 32'hA5C);
                wr(caddr(c, i), 32'(exp_coef[c * 16 + i]));
            end
        rd("c21_rb", caddr(2, 1), 32'h0002_1A5C);

        wr(12'h004, 32'h5);
        rd("mask5", 12'h004, 32'h5);
        clr_mon();
        commit();
        wait_quiet();
        exp_cnt = 1;
        check("c1_nwr", wr_cyc_q.size(), 32'd32);
        check("c1_first", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1, n + 1);
        check_stream(0, 0);
        check_stream(16, 2);
        check("c1_nupd", upd_q.size(), 32'd1);
        check("c1_upd", upd_at(0), n + 33);
        rd("c1_cnt", 12'h000, 32'h0000_0100);

        clr_mon();
        commit();
        n0 = n;
        xfer(1'b1, caddr(0, 3), 32'h0002_AAAA, 4'hF);
        check("stall_ack", 32'(r_ack), 32'd1);
        check("stall_cyc", r_t0 + r_lat, n0 + 35);
        wait_quiet();
        check("stall_upd", upd_at(0), n0 + 33);
        check_stream(0, 0);
        exp_coef[3] = 18'h2AAAA;
        rd("stall_rb", caddr(0, 3), 32'h0002_AAAA);
        exp_cnt = 2;

        clr_mon();
        @(posedge clk_i); #1;
        g = cyc;
        global_update_i = 1'b1;
        @(posedge clk_i); #1;
        global_update_i = 1'b0;
        wait_quiet();
        check("gu_nupd", upd_q.size(), 32'd1);
        check("gu_upd", upd_at(0), g + 1);
        check("gu_nwr", wr_cyc_q.size(), 32'd0);
        rd("gu_cnt", 12'h000, 32'h0000_0200);

        clr_mon();
        commit();
        wait_cycle(n + 5);
        global_update_i = 1'b1;
        @(posedge clk_i); #1;
        global_update_i = 1'b0;
        wait_quiet();
        check("gus_nupd", upd_q.size(), 32'd1);
        check("gus_upd", upd_at(0), n + 33);

        clr_mon();
        commit();
        wait_cycle(n + 33);
        global_update_i = 1'b1;
        @(posedge clk_i); #1;
        global_update_i = 1'b0;
        wait_quiet();
        check("guu_nupd", upd_q.size(), 32'd2);
        check("guu_upd0", upd_at(0), n + 33);
        check("guu_upd1", upd_at(1), n + 35);
        rd("guu_cnt", 12'h000, 32'h0000_0400);

        clr_mon();
        commit();
        wr(12'h000, 32'h1);
        check("c2_nostall", r_lat, 32'd1);
        wr(12'h000, 32'h1);
        rd("busy_rd", 12'h000, 32'h0000_0401);
        rd("busy_coef_rd", caddr(2, 0), 32'h0002_0A5C);
        wait_quiet();
        check("c2_nwr", wr_cyc_q.size(), 32'd64);
        check("c2_nupd", upd_q.size(), 32'd2);
        check("c2_upd0", upd_at(0), n + 33);
        check("c2_second", (wr_cyc_q.size() > 32) ? wr_cyc_q[32] : -1, n + 35);
        check("c2_upd1", upd_at(1), n + 67);
        check_stream(32, 0);
        check_stream(48, 2);
        rd("c2_cnt", 12'h000, 32'h0000_0600);

        wr(12'h004, 32'h0);
        clr_mon();
        commit();
        wait_quiet();
        check("m0_nwr", wr_cyc_q.size(), 32'd0);
        check("m0_upd", upd_at(0), n + 1);

        clr_mon();
        xfer(1'b1, 12'h000, 32'h1, 4'hE);
        repeat (6) @(negedge clk_i);
        check("sel_noop", 32'(upd_q.size() + wr_cyc_q.size()), 32'd0);

        wr(12'h004, 32'h8);
        clr_mon();
        commit();
        wr(12'h004, 32'h2);
        check("mask_nostall", r_lat, 32'd1);
        wait_quiet();
        check("m8_nwr", wr_cyc_q.size(), 32'd16);
        check_stream(0, 3);
        rd("mask2", 12'h004, 32'h2);
        clr_mon();
        commit();
        wait_quiet();
        check("m2_nwr", wr_cyc_q.size(), 32'd16);
        check_stream(0, 1);
        rd("final_cnt", 12'h000, 32'h0000_0900);

        xfer(1'b1, caddr(5, 0), 32'h0001_2345, 4'hF);
        check("err_wr", 32'({r_ack, r_err}), 32'b01);
        check("err_lat", r_lat, 32'd1);
        xfer(1'b0, caddr(5, 0), 32'h0, 4'hF);
        check("err_rd", 32'({r_ack, r_err}), 32'b01);
        rd("err_noalias", caddr(1, 0), 32'(exp_coef[16]));

        wr(12'h004, 32'hF);
        clr_mon();
        commit();
        while (cyc < n + 5) @(negedge clk_i);
        check("pre_rst_wr", 32'(coeff_wr_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_mid_flags", 32'({coeff_wr_o, coeff_update_o, busy_o, wb_ack_o, wb_err_o}), 32'd0);
        check("rst_mid_coeff", 32'({coeff_dat_o, coeff_adr_o, coeff_chan_o}), 32'd0);
        clr_mon();
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (50) @(negedge clk_i);
        check("rst_no_upd", upd_q.size(), 32'd0);
        check("rst_no_wr", wr_cyc_q.size(), 32'd0);
        rd("rst2_ctrl", 12'h000, 32'h0);
        rd("rst2_mask", 12'h004, 32'h0000_000F);
        rd("rst2_coef", caddr(2, 5), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/biquad8_coeff_ctrl.md
BIQUAD8_COEFF_CTRL -- requirements
Module: biquad8_coeff_ctrl

Interface
REQ-001 Parameter NCHAN, default 4: number of biquad channels served, 1..16.
REQ-002 Parameter NCOEFF, default 16: coefficients per channel, power of two, 2..64.
REQ-003 Parameter CBITS, default 18: coefficient width, at most 32.
REQ-004 Parameter ADDR_BITS, default 12: WISHBONE byte-address width, at most 32; the coefficient region SHALL hold at least NCHAN*NCOEFF words.
REQ-005 The port list SHALL be as follows.
- clk_i  in  1  sole clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  WISHBONE target strobes.
- wb_adr_i  in  ADDR_BITS  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects; only wb_sel_i[0] is honoured, and only for CTRL.
- wb_dat_o  out  32  read data.
- wb_ack_o, wb_err_o, wb_rty_o  out  1 each  termination; wb_rty_o is always 0.
- global_update_i  in  1  external update request.
- coeff_dat_o  out  CBITS  streamed coefficient.
- coeff_adr_o  out  clog2(NCOEFF)  coefficient index.
- coeff_chan_o  out  clog2(NCHAN), minimum 1  channel index.
- coeff_wr_o  out  1  coefficient strobe.
- coeff_update_o  out  1  single-cycle update pulse to all channels.
- busy_o  out  1  high while not IDLE.

Function
REQ-006 The address map SHALL be as follows.
- 0x000 CTRL. Write bit0=1 with wb_sel_i[0] requests a commit. Read: bit0 = busy_o; bits[15:8] = commit counter, 8-bit, wrapping.
- 0x004 CHMASK. R/W, bits[NCHAN-1:0] = channel enable for commit.
- Coefficient region selected by wb_adr_i[ADDR_BITS-1]=1. Word w = wb_adr_i[ADDR_BITS-2:2]; chan = w/NCOEFF; idx = w%NCOEFF. R/W shadow register, low CBITS bits; reads zero-extend.
- Any other address reads 0 and ignores writes.
REQ-007 Access to a coefficient address with chan>=NCHAN SHALL terminate with wb_err_o instead of wb_ack_o and have no effect.
REQ-008 Termination SHALL be registered: a request first seen at cycle n terminates at n+1 for one cycle. No second termination SHALL be issued for the same strobe. Termination output SHALL be qualified by wb_cyc_i.
REQ-009 Reads SHALL terminate one cycle after the request in every state.
REQ-010 Coefficient-region writes while busy_o=1 SHALL be stalled with no ack. They complete and ack one cycle after the controller returns to IDLE.
REQ-011 Writes to CTRL or CHMASK SHALL never stall. A CHMASK change while busy SHALL take effect only for the next commit.
REQ-012 State machine SHALL have states IDLE, STREAM and UPDATE.
- IDLE -> STREAM on commit request when CHMASK is nonzero.
- IDLE -> UPDATE on commit request when CHMASK is zero, or on a latched update request.
- STREAM -> UPDATE after the last enabled coefficient is streamed.
- UPDATE -> IDLE after one cycle.
REQ-013 Commit timing SHALL be as follows.
- A commit write acked at cycle n SHALL produce the first coeff_wr_o at n+1.
- CHMASK SHALL be snapshotted at cycle n.
REQ-014 STREAM order and output signals SHALL be as follows.
- Enabled channels in ascending order; within each channel, idx 0..NCOEFF-1.
- One coefficient per cycle with no gaps.
- coeff_wr_o=1 with matching coeff_chan_o, coeff_adr_o and coeff_dat_o (shadow value).
- Total popcount(mask)*NCOEFF cycles.
REQ-015 coeff_update_o SHALL pulse for exactly one cycle, in UPDATE. UPDATE SHALL immediately follow the last coeff_wr_o.
REQ-016 The commit counter SHALL increment in each UPDATE cycle caused by a commit.
REQ-017 global_update_i in IDLE SHALL enter UPDATE the next cycle.
REQ-018 global_update_i asserted during STREAM or UPDATE SHALL be latched. If in STREAM, it SHALL merge into that STREAM's single UPDATE pulse. If in UPDATE, it SHALL produce one further UPDATE after returning to IDLE.
REQ-019 A commit request while busy SHALL be acked and latched (depth 1; further requests are merged). It SHALL start a new STREAM on the first IDLE cycle.
REQ-020 A latched commit SHALL take priority over a latched global update, which merges into it.
REQ-021 Outside STREAM, coeff_wr_o SHALL be 0. In that case coeff_dat_o, coeff_adr_o and coeff_chan_o SHALL hold 0.

Reset
REQ-022 rst_ni=0 SHALL asynchronously force the following.
- State IDLE.
- All shadow coefficients 0.
- CHMASK all ones.
- Commit counter 0.
- Latched requests cleared.
- wb_ack_o, wb_err_o, wb_dat_o, coeff_* and busy_o all 0.
REQ-023 Reset mid-STREAM SHALL abort streaming with no coeff_update_o pulse. A stalled coefficient write at reset SHALL be dropped without ack.
REQ-024 Operation SHALL resume on the first clk_i edge after rst_ni deasserts.

Verification
REQ-025 NCHAN=4, NCOEFF=16: write 0x3FFFF to chan 2 idx 5, then read it back -> ack at n+1, read data 0x0003FFFF.
REQ-026 CHMASK=0x5, commit acked at n -> 32 consecutive coeff_wr_o from n+1 (chan 0 then chan 2), then coeff_update_o at n+33, counter=1.
REQ-027 Coefficient write during STREAM -> no ack until IDLE. The streamed value is the old value. Ack comes one cycle after IDLE.
REQ-028 global_update_i in IDLE -> single coeff_update_o next cycle, no coeff_wr_o, counter unchanged. Asserted mid-STREAM -> still exactly one pulse.
REQ-029 Two commits issued during STREAM -> exactly one additional STREAM follows; counter +2 in total.
REQ-030 Access to chan 5 with NCHAN=4 -> wb_err_o, no ack. rst_ni low mid-STREAM -> all outputs 0 immediately and no update pulse.
